pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the stall/flush inputs of the PC register, the IF/ID latch and the ID/EX latch.
- Tracks outstanding register writes in a per-register scoreboard, because the datapath has no forwarding.
- Sequences bubble insertion for RAW hazards, redirect flushes on branch mispredicts, and full-pipe freezes while data memory is busy.

Parameters:
REG_NO_BITS, 4, width of register numbers (2^REG_NO_BITS scoreboard entries)
WB_LATENCY, 3, cycles from an instruction entering the ID/EX latch until its result is readable in ID
FLUSH_CYCLES, 1, extra cycles of IF/ID flush after the mispredict cycle (I-mem redirect latency); 0 legal
CNT_BITS, 2, scoreboard counter width; must hold WB_LATENCY

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
decValid  in  1  ID stage holds a valid instruction
decRs1  in  REG_NO_BITS  ID source register 1
decRs2  in  REG_NO_BITS  ID source register 2
decUseRs1  in  1  instruction reads rs1
decUseRs2  in  1  instruction reads rs2
decWrReg  in  1  instruction writes a register
decRd  in  REG_NO_BITS  ID destination register
brMispredict  in  1  EX resolved a branch against the fetched path (level, one cycle per branch)
memBusy  in  1  data memory not ready; MEM cannot complete this cycle
pcStall  out  1  hold PC
ifStall  out  1  hold IF/ID latch
ifFlush  out  1  zero IF/ID latch
idStall  out  1  hold ID/EX latch
idFlush  out  1  load bubble into ID/EX latch
hazard  out  1  debug: RAW hazard detected this cycle

Behaviour:
- While reset is low, asynchronously:
  - state <= RUN, all scoreboard counters <= 0, flush counter <= 0.
  - Outputs forced to: ifFlush=1, idFlush=1, all stalls 0, hazard=0.
- States: RUN, FLUSH, MEMWAIT. Outputs are combinational from state, counters and inputs; no added latency.
- Priority each cycle: memBusy > brMispredict > FLUSH state > RAW hazard > normal.
- memBusy=1, in any state:
  - Outputs: pcStall=ifStall=idStall=1, both flushes 0.
  - Scoreboard and flush counter frozen; go to or stay in MEMWAIT.
  - brMispredict ignored, because EX is frozen and holds it.
  - On memBusy=0, return to the saved prior state (RUN or FLUSH).
- brMispredict=1 and memBusy=0:
  - Outputs: ifFlush=idFlush=1, stalls 0, no scoreboard issue.
  - If FLUSH_CYCLES>0: go to FLUSH with counter=FLUSH_CYCLES; otherwise stay in RUN.
  - A mispredict arriving in FLUSH reloads the counter.
- FLUSH state:
  - Outputs: ifFlush=idFlush=1; hazard check suppressed.
  - Counter decrements each cycle; at 1, return to RUN next cycle.
- RAW hazard, in RUN:
  - Condition: decValid & ((decUseRs1 & cnt[decRs1]!=0) | (decUseRs2 & cnt[decRs2]!=0)).
  - Outputs: pcStall=ifStall=1, idFlush=1 (bubble), hazard=1, no issue.
- Issue: RUN, no hazard, decValid=1, decWrReg=1, memBusy=0 → cnt[decRd] <= WB_LATENCY.
- Countdown: every non-frozen cycle, each nonzero counter decrements by 1, except the entry being issued, which is loaded.
  - An issue to a register with a nonzero count reloads it (WAW: the newest write wins).
- Register 0 is tracked like any other register; no special case.
- Flushed ID instructions never issue, so mispredicts need no scoreboard squash.

Decomposition:
- Shared pipeline package:
  - state encodings (RUN=0, FLUSH=1, MEMWAIT=2);
  - REG_NO_BITS;
  - pipeline depth constant from which WB_LATENCY derives.
- One sub-module, hazard_scoreboard:
  - counter array, issue/load, decrement, freeze;
  - two combinational busy lookups.
- The FSM stays in the top level.

Test Plan:
- Reset mid-run: reset=0 with cnt[5]=2 → all counters 0, state RUN, ifFlush=idFlush=1 immediately (no clock edge); after release a read of r5 gives no stall.
- Back-to-back dependency: issue write r3, next cycle read r3 → hazard, pcStall, ifStall, idFlush high for exactly 3 cycles; instruction issues on the 4th.
- Independent read: issue write r3, next cycle read r4 with decUseRs2=0 on r3 → no stall.
- Mispredict (FLUSH_CYCLES=1): brMispredict pulse → ifFlush=idFlush=1 for 2 cycles, then RUN; a pending r7 count still decrements during those cycles.
- memBusy 4 cycles with cnt[2]=2 and brMispredict held: all stalls high, flushes low, cnt[2] stays 2; on release the flush sequence starts; stall on a dependent read of r2 ends 2 cycles later.
- WAW reload: write r6, one cycle later write r6 again → a reader of r6 stalls until 3 cycles after the second issue.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the stall/flush controller of the 5-stage pipe.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  localparam int unsigned REG_NO_BITS  = 4;
  localparam int unsigned PIPE_DEPTH   = 5;
  // A result written in WB becomes readable in ID after EX, MEM and WB have passed.
  localparam int unsigned WB_LATENCY   = PIPE_DEPTH - 2;
  localparam int unsigned CNT_BITS     = 2;
  localparam int unsigned FLUSH_CYCLES = 1;

  function automatic int unsigned bits_for(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register countdown of outstanding writes; nonzero means the value is not yet readable in ID.
module hazard_scoreboard #(
  parameter int unsigned REG_NO_BITS = 4,
  parameter int unsigned CNT_BITS    = 2,
  parameter int unsigned WB_LATENCY  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   freeze,
  input  logic                   issue,
  input  logic [REG_NO_BITS-1:0] issue_rd,
  input  logic [REG_NO_BITS-1:0] rs1,
  input  logic [REG_NO_BITS-1:0] rs2,
  output logic                   rs1_busy_c,
  output logic                   rs2_busy_c
);

  localparam int unsigned NREGS = 2 ** REG_NO_BITS;

  logic [CNT_BITS-1:0] cnt_q [NREGS];
  logic [CNT_BITS-1:0] cnt_d [NREGS];

  // Issued entry is (re)loaded so the newest write wins; every other busy entry counts down.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!freeze) begin
        if (issue && (issue_rd == REG_NO_BITS'(i))) begin
          cnt_d[i] = CNT_BITS'(WB_LATENCY);
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
        end
      end
    end
  end

  assign rs1_busy_c = (cnt_q[rs1] != '0);
  assign rs2_busy_c = (cnt_q[rs2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: RAW bubbles from the scoreboard, mispredict flushes, memory-busy freezes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_NO_BITS  = pipe_hazard_ctrl_pkg::REG_NO_BITS,
  parameter int unsigned WB_LATENCY   = pipe_hazard_ctrl_pkg::WB_LATENCY,
  parameter int unsigned FLUSH_CYCLES = pipe_hazard_ctrl_pkg::FLUSH_CYCLES,
  parameter int unsigned CNT_BITS     = pipe_hazard_ctrl_pkg::CNT_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   decValid,
  input  logic [REG_NO_BITS-1:0] decRs1,
  input  logic [REG_NO_BITS-1:0] decRs2,
  input  logic                   decUseRs1,
  input  logic                   decUseRs2,
  input  logic                   decWrReg,
  input  logic [REG_NO_BITS-1:0] decRd,
  input  logic                   brMispredict,
  input  logic                   memBusy,
  output logic                   pcStall,
  output logic                   ifStall,
  output logic                   ifFlush,
  output logic                   idStall,
  output logic                   idFlush,
  output logic                   hazard
);

  localparam int unsigned FC_BITS = bits_for(FLUSH_CYCLES);

  state_e              state_q, state_d;
  state_e              saved_q, saved_d;
  state_e              cur_state_c;
  logic [FC_BITS-1:0]  fcnt_q, fcnt_d;
  logic                rs1_busy_c, rs2_busy_c;
  logic                raw_c, issue_c, freeze_c;

  hazard_scoreboard #(
    .REG_NO_BITS (REG_NO_BITS),
    .CNT_BITS    (CNT_BITS),
    .WB_LATENCY  (WB_LATENCY)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (reset),
    .freeze     (freeze_c),
    .issue      (issue_c),
    .issue_rd   (decRd),
    .rs1        (decRs1),
    .rs2        (decRs2),
    .rs1_busy_c (rs1_busy_c),
    .rs2_busy_c (rs2_busy_c)
  );

  // Leaving MEMWAIT resumes the saved state in the same cycle, so no latency is added.
  assign cur_state_c = (state_q == ST_MEMWAIT) ? saved_q : state_q;
  assign raw_c = decValid & ((decUseRs1 & rs1_busy_c) | (decUseRs2 & rs2_busy_c));

  always_comb begin
    state_d  = cur_state_c;
    saved_d  = saved_q;
    fcnt_d   = fcnt_q;
    issue_c  = 1'b0;
    freeze_c = 1'b0;
    pcStall  = 1'b0;
    ifStall  = 1'b0;
    ifFlush  = 1'b0;
    idStall  = 1'b0;
    idFlush  = 1'b0;
    hazard   = 1'b0;

    if (memBusy) begin
      // EX is frozen too, so a mispredict it holds is seen again after release.
      pcStall  = 1'b1;
      ifStall  = 1'b1;
      idStall  = 1'b1;
      freeze_c = 1'b1;
      state_d  = ST_MEMWAIT;
      if (state_q != ST_MEMWAIT) begin
        saved_d = state_q;
      end
    end else if (brMispredict) begin
      ifFlush = 1'b1;
      idFlush = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_d = ST_FLUSH;
        fcnt_d  = FC_BITS'(FLUSH_CYCLES);
      end else begin
        state_d = ST_RUN;
      end
    end else if (cur_state_c == ST_FLUSH) begin
      ifFlush = 1'b1;
      idFlush = 1'b1;
      if (fcnt_q <= FC_BITS'(1)) begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q - FC_BITS'(1);
      end
    end else if (raw_c) begin
      pcStall = 1'b1;
      ifStall = 1'b1;
      idFlush = 1'b1;
      hazard  = 1'b1;
    end else begin
      state_d = ST_RUN;
      issue_c = decValid & decWrReg;
    end

    if (!reset) begin
      pcStall = 1'b0;
      ifStall = 1'b0;
      ifFlush = 1'b1;
      idStall = 1'b0;
      idFlush = 1'b1;
      hazard  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a timebase model.
module tb_pipe_hazard_ctrl;

  localparam int WBL = 3;
  localparam int FC  = 1;
  localparam int NR  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       decValid, decUseRs1, decUseRs2, decWrReg, brMispredict, memBusy;
  logic [3:0] decRs1, decRs2, decRd;
  logic       pcStall, ifStall, ifFlush, idStall, idFlush, hazard;

  int checks = 0;
  int errors = 0;

  // Model: "active" counts unfrozen cycles; a register is readable once active reaches ready_at.
  int ready_at [NR];
  int active;
  int flush_end;
  int hz_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .decValid(decValid), .decRs1(decRs1), .decRs2(decRs2),
    .decUseRs1(decUseRs1), .decUseRs2(decUseRs2), .decWrReg(decWrReg), .decRd(decRd),
    .brMispredict(brMispredict), .memBusy(memBusy), .pcStall(pcStall), .ifStall(ifStall),
    .ifFlush(ifFlush), .idStall(idStall), .idFlush(idFlush), .hazard(hazard)
  );

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ready_at[i] = 0;
    active    = 0;
    flush_end = -1;
  endtask

  task automatic check6(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pcStall, ifStall, ifFlush, idStall, idFlush, hazard};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={pc,if,ifF,id,idF,hz}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    decValid = 0; decUseRs1 = 0; decUseRs2 = 0; decWrReg = 0;
    decRs1 = 0; decRs2 = 0; decRd = 0; brMispredict = 0; memBusy = 0;
  endtask

  // One pipeline cycle: drive at negedge, check just after, then advance the model.
  task automatic cycle(input string tag, input bit v, input logic [3:0] r1, input bit u1,
                       input logic [3:0] r2, input bit u2, input bit wr, input logic [3:0] rd,
                       input bit br, input bit mb);
    logic [5:0] exp;
    bit raw;
    @(negedge clk);
    decValid = v; decRs1 = r1; decUseRs1 = u1; decRs2 = r2; decUseRs2 = u2;
    decWrReg = wr; decRd = rd; brMispredict = br; memBusy = mb;
    #1;
    raw = v && ((u1 && active < ready_at[r1]) || (u2 && active < ready_at[r2]));
    if (mb) exp = 6'b110100;
    else if (br) begin
      exp = 6'b001010;
      flush_end = active + FC;
    end
    else if (active <= flush_end) exp = 6'b001010;
    else if (raw) exp = 6'b110011;
    else begin
      exp = 6'b000000;
      if (v && wr) ready_at[rd] = active + 1 + WBL;
    end
    check6(tag, exp);
    if (hazard) hz_cnt++;
    if (!mb) active++;
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    decValid = 1; decWrReg = 1; decRd = 4'd9; decUseRs1 = 1; decRs1 = 4'd5;
    #2 reset = 1'b0;
    #1 check6("reset_async", 6'b001010);
    model_reset();
    @(posedge clk);
    #1 check6("reset_hold", 6'b001010);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #1 check6("reset_state", 6'b001010);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-run while r5 still has two cycles outstanding.
    cycle("wr_r5",      1, 0, 0, 0, 0, 1, 4'd5, 0, 0);
    cycle("idle_r5",    0, 0, 0, 0, 0, 0, 0,    0, 0);
    reset_mid_run();
    cycle("rd_r5_post", 1, 4'd5, 1, 0, 0, 0, 0, 0, 0);

    // Back-to-back dependency: exactly three bubble cycles.
    cycle("wr_r3", 1, 0, 0, 0, 0, 1, 4'd3, 0, 0);
    hz_cnt = 0;
    for (int i = 0; i < 4; i++) cycle("raw_r3", 1, 4'd3, 1, 0, 0, 1, 4'd8, 0, 0);
    checks++;
    assert (hz_cnt === 3) else begin
      errors++;
      $error("FAIL raw_len observed=%0d expected=3", hz_cnt);
    end
    cycle("after_raw", 1, 4'd8, 1, 0, 0, 0, 0, 0, 0);

    // Independent read; rs2 names the busy register but is unused.
    cycle("wr_r3b", 1, 0, 0, 0, 0, 1, 4'd3, 0, 0);
    cycle("indep",  1, 4'd4, 1, 4'd3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Mispredict with r7 pending.
    cycle("wr_r7",   1, 0, 0, 0, 0, 1, 4'd7, 0, 0);
    cycle("mispred", 1, 4'd7, 1, 0, 0, 1, 4'd1, 1, 0);
    cycle("flush1",  1, 4'd7, 1, 0, 0, 1, 4'd1, 0, 0);
    cycle("rd_r7",   1, 4'd7, 1, 0, 0, 0, 0, 0, 0);
    cycle("rd_r7b",  1, 4'd7, 1, 0, 0, 0, 0, 0, 0);

    // Memory busy with a mispredict held in EX and r2 outstanding.
    cycle("wr_r2",  1, 0, 0, 0, 0, 1, 4'd2, 0, 0);
    cycle("cnt2",   0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("membusy", 1, 4'd2, 1, 0, 0, 0, 0, 1, 1);
    cycle("rel_br", 1, 4'd2, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle("rd_r2", 1, 0, 0, 4'd2, 1, 0, 0, 0, 0);

    // WAW reload extends the stall.
    cycle("wr_r6a", 1, 0, 0, 0, 0, 1, 4'd6, 0, 0);
    cycle("wr_r6b", 1, 0, 0, 0, 0, 1, 4'd6, 0, 0);
    for (int i = 0; i < 5; i++) cycle("rd_r6", 1, 4'd6, 1, 0, 0, 0, 0, 0, 0);

    // Random traffic over a few registers to provoke hazards and overlaps.
    for (int i = 0; i < 800; i++) begin
      cycle("rand",
            bit'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), bit'($urandom_range(0, 11) == 0),
            bit'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
